if_fetch_queue: RTL and testbench

- Instruction-fetch stage logic directly downstream of the PC register.
- Takes the current fetch PC and issues it to instruction memory over a valid/grant request channel.
- Collects in-order responses into a small queue and presents {PC, instruction} to the IF/ID boundary.
- Generates the IF stall (bubble) that holds the PC register; absorbs pipeline flushes, including discard of in-flight responses.

---
 rtl/if_pkg.sv | 18 +
 rtl/if_fetch_ring.sv | 129 ++++++++++++
 rtl/if_fetch_queue.sv | 112 +++++++++++
 tb/tb_if_fetch_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch queue
//
// Purpose: width of PC/instruction, the NOP driven to ID when the queue head is
// empty, and the per-entry record held by the fetch ring.
package if_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ring.sv
// rtl/if_fetch_ring.sv - DEPTH-entry circular buffer of in-order fetch entries
//
// Purpose: entries are allocated at the write pointer when a request is accepted,
// filled at the fill pointer when a response returns, and freed at the read
// pointer on pop. All three operations happen in the same order, so three
// pointers plus a count fully describe the buffer.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_i             drop every entry and rewind all pointers (flush)
//   alloc_i, alloc_pc_i allocate the next entry with this PC
//   fill_i, fill_insn_i fill the oldest unfilled entry with this instruction
//   pop_i               free the head entry
//   count_o             allocated entries
//   inflight_o          allocated entries still waiting for their response
//   head_valid_o        head entry allocated and filled
//   head_pc_o           PC of the head entry
//   head_insn_o         instruction of the head entry
module if_fetch_ring
    import if_pkg::*;
#(
    parameter int   DEPTH = 2,
    localparam int  PTR_W = $clog2(DEPTH),
    localparam int  CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              alloc_i,
    input  logic [XLEN-1:0]   alloc_pc_i,
    input  logic              fill_i,
    input  logic [XLEN-1:0]   fill_insn_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  inflight_o,
    output logic              head_valid_o,
    output logic [XLEN-1:0]   head_pc_o,
    output logic [XLEN-1:0]   head_insn_o
);

    fetch_entry_t       ent_q [DEPTH];
    fetch_entry_t       ent_d [DEPTH];
    logic [DEPTH-1:0]   alloc_q, alloc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // The caller guarantees the three operations never target the same slot:
    // alloc needs a free slot, fill needs an allocated unfilled slot, and pop
    // needs a filled head.
    always_comb begin
        ent_d      = ent_q;
        alloc_d    = alloc_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (clear_i) begin
            alloc_d    = '0;
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].filled = 1'b0;
            end
        end else begin
            if (alloc_i) begin
                ent_d[wr_ptr_q].pc     = alloc_pc_i;
                ent_d[wr_ptr_q].filled = 1'b0;
                alloc_d[wr_ptr_q]      = 1'b1;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end
            if (fill_i) begin
                ent_d[fill_ptr_q].insn   = fill_insn_i;
                ent_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d               = fill_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                alloc_d[rd_ptr_q]      = 1'b0;
                ent_d[rd_ptr_q].filled = 1'b0;
                rd_ptr_d               = rd_ptr_q + PTR_W'(1);
            end
            case ({alloc_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alloc_q    <= '0;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            alloc_q    <= alloc_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        inflight_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_q[i] && !ent_q[i].filled) begin
                inflight_o = inflight_o + CNT_W'(1);
            end
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = alloc_q[rd_ptr_q] && ent_q[rd_ptr_q].filled;
    assign head_pc_o    = ent_q[rd_ptr_q].pc;
    assign head_insn_o  = ent_q[rd_ptr_q].insn;

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch request issue, response queue and IF stall/flush
//
// Purpose: issues the current PC to instruction memory, queues in-order
// responses, presents {PC, instruction} to ID, holds the PC register while a
// fetch is not accepted, and discards responses belonging to flushed fetches.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   pc_f                                current fetch PC
//   bubble_f                            1 = hold the PC register this cycle
//   flush_if                            drop all fetched and in-flight instructions
//   imem_req, imem_addr, imem_gnt       fetch request channel
//   imem_rvalid, imem_rdata             in-order response channel
//   stall_d                             ID not consuming this cycle
//   valid_d, pc_d, insn_d               head entry presented to ID
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   pc_f,
    output logic              bubble_f,
    input  logic              flush_if,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              stall_d,
    output logic              valid_d,
    output logic [XLEN-1:0]   pc_d,
    output logic [XLEN-1:0]   insn_d
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             head_valid;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  head_insn;
    logic             accept;
    logic             pop;
    logic             fill;
    logic             drop;

    // rst_n gates the request so nothing is issued while held in reset.
    assign imem_req  = rst_n && !flush_if && (count < CNT_W'(DEPTH));
    assign imem_addr = pc_f;
    assign accept    = imem_req && imem_gnt;
    assign bubble_f  = !rst_n || (!accept && !flush_if);

    assign pop  = head_valid && !stall_d && !flush_if;
    assign drop = imem_rvalid && (discard_q != '0);
    assign fill = imem_rvalid && (discard_q == '0) && (inflight != '0) && !flush_if;

    // On a flush every in-flight fetch becomes a response to throw away; a
    // response arriving in the flush cycle itself is one of those, already gone.
    always_comb begin
        discard_d = discard_q;
        if (flush_if) begin
            discard_d = discard_q + inflight;
            if (imem_rvalid && (discard_d != '0)) begin
                discard_d = discard_d - CNT_W'(1);
            end
        end else if (drop) begin
            discard_d = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_q <= '0;
        end else begin
            discard_q <= discard_d;
        end
    end

    if_fetch_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (flush_if),
        .alloc_i      (accept),
        .alloc_pc_i   (pc_f),
        .fill_i       (fill),
        .fill_insn_i  (imem_rdata),
        .pop_i        (pop),
        .count_o      (count),
        .inflight_o   (inflight),
        .head_valid_o (head_valid),
        .head_pc_o    (head_pc),
        .head_insn_o  (head_insn)
    );

    assign valid_d = head_valid;
    assign pc_d    = head_pc;
    assign insn_d  = head_valid ? head_insn : NOP_INSN;

    // A response with nothing outstanding and nothing to discard is a memory
    // protocol violation; the data is ignored.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_rvalid && (discard_q == '0) && (inflight == '0)));
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [XLEN-1:0]   pc_f;
    logic              bubble_f;
    logic              flush_if;
    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [XLEN-1:0]   imem_rdata;
    logic              stall_d;
    logic              valid_d;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   insn_d;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_f        (pc_f),
        .bubble_f    (bubble_f),
        .flush_if    (flush_if),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall_d     (stall_d),
        .valid_d     (valid_d),
        .pc_d        (pc_d),
        .insn_d      (insn_d)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // expected queue contents (PCs, oldest first) and how many have returned
    logic [31:0] sb_pc [$];
    int          nfilled = 0;

    // memory model: pending responses in order
    logic [31:0] mem_addr [$];
    int          mem_due  [$];
    int          mem_ep   [$];

    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          n_pop = 0;
    logic [31:0] pc_model = 32'h0;
    logic [31:0] flush_target = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic present;
        logic exp_req;
        logic accept;
        logic exp_valid;
        logic pop;
        int   ep;
        present = (mem_due.size() > 0) && (mem_due[0] <= cyc);
        ep = 0;
        if (present) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hAAAA_0000 + mem_addr[0];
            ep          = mem_ep[0];
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        pc_f = pc_model;
        @(negedge clk);
        exp_req   = !flush_if && (sb_pc.size() < DEPTH);
        accept    = exp_req && imem_gnt;
        exp_valid = nfilled > 0;
        check_eq("imem_req", 32'(imem_req), 32'(exp_req));
        check_eq("bubble_f", 32'(bubble_f), 32'(!accept && !flush_if));
        if (exp_req) check_eq("imem_addr", imem_addr, pc_f);
        check_eq("valid_d", 32'(valid_d), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("pc_d", pc_d, sb_pc[0]);
            check_eq("insn_d", insn_d, 32'hAAAA_0000 + sb_pc[0]);
        end else begin
            check_eq("insn_d_nop", insn_d, NOP_INSN);
        end
        pop = exp_valid && !stall_d && !flush_if;
        if (present) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
            void'(mem_ep.pop_front());
            if (ep == epoch && !flush_if) nfilled++;
        end
        if (pop) begin
            void'(sb_pc.pop_front());
            nfilled--;
            n_pop++;
        end
        if (accept) begin
            sb_pc.push_back(pc_f);
            mem_addr.push_back(pc_f);
            mem_due.push_back(cyc + lat);
            mem_ep.push_back(epoch);
        end
        if (flush_if) begin
            sb_pc.delete();
            nfilled  = 0;
            epoch++;
            pc_model = flush_target;
        end else if (accept) begin
            pc_model = pc_model + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        imem_gnt = 1'b0;
        stall_d  = 1'b0;
        for (int i = 0; i < 40 && (sb_pc.size() > 0 || mem_due.size() > 0); i++) step();
        check_eq("drain_queue", 32'(sb_pc.size()), 32'd0);
        check_eq("drain_mem", 32'(mem_due.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid_d", 32'(valid_d), 32'd0);
        check_eq("rst_insn_d", insn_d, NOP_INSN);
        check_eq("rst_pc_d", pc_d, 32'd0);
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_bubble_f", 32'(bubble_f), 32'd1);
        sb_pc.delete();
        nfilled = 0;
        mem_addr.delete();
        mem_due.delete();
        mem_ep.delete();
        imem_rvalid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        imem_gnt    = 1'b1;
        stall_d     = 1'b0;
        flush_if    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pc_f        = 32'h0;
        #1;
        do_reset();

        // zero-wait memory, PCs 0,4,8,...
        lat = 1;
        run(10);

        // ID stall fills the queue, then release
        stall_d = 1'b1;
        run(4);
        stall_d = 1'b0;
        run(6);

        // grant withheld for 3 cycles
        imem_gnt = 1'b0;
        run(3);
        imem_gnt = 1'b1;
        run(4);
        drain();

        // two fetches in flight with 3-cycle latency, flush before any returns
        lat = 3;
        imem_gnt = 1'b1;
        run(2);
        flush_target = 32'h100;
        flush_if = 1'b1;
        run(1);
        flush_if = 1'b0;
        run(12);
        drain();

        // flush coinciding with the first of two responses
        lat = 3;
        imem_gnt = 1'b1;
        run(3);
        flush_target = 32'h180;
        flush_if = 1'b1;
        run(1);
        flush_if = 1'b0;
        run(12);
        drain();

        // reset with a full queue, restart from a new PC
        lat = 1;
        imem_gnt = 1'b1;
        stall_d = 1'b1;
        run(4);
        do_reset();
        pc_model = 32'h200;
        stall_d = 1'b0;
        imem_gnt = 1'b1;
        run(8);
        drain();

        check_eq("pops_seen", 32'(n_pop >= 12), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
